// File: rtl/alarm_ringer_pkg.sv
// Shared definitions for the alarm ringer: time field widths, the no-alarm code
// and the ringer state encoding.
package alarm_ringer_pkg;

    localparam int unsigned HourW  = 5;
    localparam int unsigned MinW   = 6;
    localparam int unsigned TimerW = 10;

    localparam logic [HourW-1:0] NO_ALARM_HOUR = 5'd24;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRinging = 2'd1,
        StSnooze  = 2'd2
    } ring_state_e;

endpackage

// File: rtl/alarm_ringer_sec_countdown.sv
// Loadable seconds down-counter shared by the ringing and snooze phases.
// A load always wins over a coincident sec_tick; the count holds at zero.
module alarm_ringer_sec_countdown
    import alarm_ringer_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [TimerW-1:0] load_value_i,
    input  logic              sec_tick_i,
    output logic              expire_o
);

    logic [TimerW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (sec_tick_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = sec_tick_i && (count_q == TimerW'(1));

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: detects entry into the alarm minute and sequences ring, snooze
// and dismiss, driving the buzzer/LED and a status for the display mux.
module alarm_ringer
    import alarm_ringer_pkg::*;
#(
    parameter int unsigned RING_SECONDS   = 60,
    parameter int unsigned SNOOZE_SECONDS = 300,
    parameter int unsigned MAX_SNOOZE     = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sec_tick,
    input  logic            real_quarter,
    input  logic [HourW-1:0] cur_hours,
    input  logic [MinW-1:0]  cur_minutes,
    input  logic [HourW-1:0] alarm_hours,
    input  logic [MinW-1:0]  alarm_minutes,
    input  logic            stop,
    input  logic            snooze,
    output logic            ringing,
    output logic            buzz,
    output logic            snoozing,
    output logic [1:0]      snooze_count,
    output logic [1:0]      state
);

    localparam logic [TimerW-1:0] RingLoad   = TimerW'(RING_SECONDS);
    localparam logic [TimerW-1:0] SnoozeLoad = TimerW'(SNOOZE_SECONDS);
    localparam logic [1:0]        MaxSnooze  = 2'(MAX_SNOOZE);

    ring_state_e       state_q, state_d;
    logic [1:0]        count_q, count_d;
    logic              buzz_q, buzz_d;
    logic              match_prev_q;
    logic              alarm_set, match, trigger;
    logic              timer_load, timer_expire;
    logic [TimerW-1:0] timer_value;

    assign alarm_set = (alarm_hours != NO_ALARM_HOUR);
    assign match     = alarm_set && (cur_hours == alarm_hours) && (cur_minutes == alarm_minutes);
    assign trigger   = match && !match_prev_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        timer_load  = 1'b0;
        timer_value = RingLoad;
        case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d    = StRinging;
                    timer_load = 1'b1;
                    count_d    = 2'd0;
                end
            end
            StRinging: begin
                if (!alarm_set) begin
                    state_d = StIdle;
                end else if (stop) begin
                    state_d = StIdle;
                    count_d = 2'd0;
                end else if (snooze && (count_q < MaxSnooze)) begin
                    state_d     = StSnooze;
                    timer_load  = 1'b1;
                    timer_value = SnoozeLoad;
                    count_d     = count_q + 2'd1;
                end else if (timer_expire) begin
                    state_d = StIdle;
                end
            end
            StSnooze: begin
                if (!alarm_set || stop) begin
                    state_d = StIdle;
                    count_d = 2'd0;
                end else if (timer_expire) begin
                    state_d    = StRinging;
                    timer_load = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Registering against the next state keeps buzz low on the edge that leaves ringing.
        buzz_d = (state_d == StRinging) && real_quarter;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            count_q      <= 2'd0;
            buzz_q       <= 1'b0;
            match_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            buzz_q       <= buzz_d;
            match_prev_q <= match;
        end
    end

    alarm_ringer_sec_countdown u_countdown (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_i       (timer_load),
        .load_value_i (timer_value),
        .sec_tick_i   (sec_tick),
        .expire_o     (timer_expire)
    );

    assign ringing      = (state_q == StRinging);
    assign snoozing     = (state_q == StSnooze);
    assign snooze_count = count_q;
    assign state        = state_q;
    assign buzz         = buzz_q;

endmodule

// File: doc/alarm_ringer.md
Name: alarm_ringer

Overview:
- Consumer side of the alarm-setting interface: takes the committed alarm time and the running timekeeper time, and decides when the alarm rings, snoozes and stops.
- Sits beside the alarm setting wrapper. It takes that wrapper's alarm_hours/alarm_minutes outputs and drives the buzzer/LED plus a status to the top-level display mux.
- alarm_hours == 24 is the "no alarm" code and is never matched.

Parameters:
- RING_SECONDS, 60, seconds the alarm rings before auto-dismiss (1..255)
- SNOOZE_SECONDS, 300, seconds spent in snooze before re-ringing (1..1023)
- MAX_SNOOZE, 3, snoozes allowed per alarm event (1..3)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- sec_tick  input  1  one-clk pulse per second from the timekeeper
- real_quarter  input  1  quarter-second blink level from the existing blink source
- cur_hours  input  5  current time, hours 0..23
- cur_minutes  input  6  current time, minutes 0..59
- alarm_hours  input  5  committed alarm hour 0..23; 24 = no alarm
- alarm_minutes  input  6  committed alarm minute 0..59
- stop  input  1  debounced one-clk dismiss pulse
- snooze  input  1  debounced one-clk snooze pulse
- ringing  output  1  high in RINGING
- buzz  output  1  ringing gated by real_quarter (buzz = ringing & real_quarter, registered)
- snoozing  output  1  high in SNOOZE
- snooze_count  output  2  snoozes used in the current event
- state  output  2  0 IDLE, 1 RINGING, 2 SNOOZE

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; ringing=0; buzz=0; snoozing=0; snooze_count=0.
  - timer=0; match_prev=1. Setting match_prev to 1 blocks a spurious trigger if reset is released inside the alarm minute.
- match (combinational):
  - match = (alarm_hours != 24) && (cur_hours == alarm_hours) && (cur_minutes == alarm_minutes).
  - match_prev is registered every clk.
- trigger = match && !match_prev. This fires once per entry into the alarm minute, whether that entry comes from the clock advancing or from an alarm set to the current minute.
- IDLE:
  - On trigger, go to RINGING on the next edge; timer=RING_SECONDS; snooze_count=0.
  - stop and snooze are ignored.
- RINGING:
  - Priority order: clear > stop > snooze > timeout. clear means alarm_hours becomes 24.
  - clear: go to IDLE next edge.
  - stop: go to IDLE; snooze_count=0.
  - snooze with snooze_count < MAX_SNOOZE: go to SNOOZE; timer=SNOOZE_SECONDS; snooze_count+1.
  - snooze with snooze_count == MAX_SNOOZE: ignored, keep ringing.
  - timeout: on sec_tick, timer decrements. On the sec_tick where timer==1, go to IDLE (auto-dismiss). Total ring time is RING_SECONDS sec_ticks.
  - A trigger while RINGING is ignored.
- SNOOZE:
  - Priority order: clear > stop > expiry.
  - clear or stop: go to IDLE; snooze_count=0.
  - Expiry: on sec_tick, timer decrements. On the sec_tick where timer==1, go to RINGING; timer=RING_SECONDS.
  - snooze and trigger are ignored.
- Output latency:
  - ringing/snoozing/state update on the same edge as the transition.
  - buzz follows real_quarter with one clk of latency while ringing, and is 0 otherwise.
- Timer width: 10 bits. It never underflows because it is reloaded on every entry to RINGING/SNOOZE.
- Alarm changed (not cleared) mid-event: the current event continues. Only the 24 code aborts it.
- After a dismiss inside the alarm minute, there is no re-trigger until the minute is left and re-entered.
- sec_tick coinciding with stop/snooze: the button wins and the timer reload takes precedence over the decrement.

Decomposition:
- Shared clock package holds:
  - NO_ALARM_HOUR=24.
  - State encodings IDLE/RINGING/SNOOZE.
  - Hour/minute widths (5/6).
- Natural sub-module: sec_countdown, a 10-bit loadable down-counter.
  - Inputs: load, load_value, sec_tick.
  - Output: expire = (count==1 && sec_tick).
  - Instantiated once and shared by RINGING and SNOOZE.

Test Plan:
- Alarm 07:30, time advances 07:29→07:30: ringing=1 one clk after the minute change; buzz toggles with real_quarter. After 60 sec_ticks with no button: IDLE, ringing=0, no re-trigger for the rest of 07:30.
- Ringing, snooze pulse: SNOOZE, snooze_count=1. After 300 sec_ticks: RINGING. Repeat 3 snoozes, then a 4th snooze pulse: stays RINGING with snooze_count=3.
- Ringing, stop and snooze asserted in the same clk: IDLE with snooze_count=0, and no re-ring in the same minute.
- SNOOZE, alarm_hours driven to 24: IDLE next clk; ringing, snoozing and buzz all 0.
- Time held at 12:00, alarm set from 24 to 12:00: trigger fires immediately. Alarm 24 with cur_hours 24-equivalent patterns: never rings.
- reset_n low mid-RINGING: all outputs 0 asynchronously. Release inside the alarm minute: stays IDLE (match_prev=1).
